fifo_stream_reader: RTL

Drain stage that sits directly downstream of the `fifo` block. It issues `read_en` pulses into the FIFO, captures each word one cycle later from the FIFO's registered `data_out`, and presents the words on a valid/ready stream. Every `PKT_LEN` words are framed with `m_last`. A small credit-checked output buffer guarantees that no word read from the FIFO is ever dropped, whatever the downstream back-pressure.

---
 rtl/fifo_stream_pkg.sv | 21 ++
 rtl/stream_buffer.sv | 61 ++++++
 rtl/fifo_stream_reader.sv | 79 +++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared widths, word type and sizing helper for the FIFO drain stage
package fifo_stream_pkg;

  localparam int FIFO_W     = 32;
  localparam int WORD_CNT_W = 16;

  typedef logic [FIFO_W-1:0] fifo_word_t;

  // Bits needed to hold values 0..value-1, never fewer than one bit
  function automatic int clog2_min1(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/stream_buffer.sv
// rtl/stream_buffer.sv - small circular buffer holding words captured from the FIFO
module stream_buffer
  import fifo_stream_pkg::*;
#(
  parameter  int W  = FIFO_W,
  parameter  int D  = 3,
  localparam int PW = clog2_min1(D),
  localparam int OW = clog2_min1(D + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_data,
  output logic [OW-1:0] o_occ
);

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;

  // Pointers step through 0..D-1 and wrap, so D need not be a power of two
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(D - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Word storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Head word is forced to zero when empty so the stream never shows stale data
  assign o_head_data = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains the FIFO into a framed valid/ready stream without ever dropping a word
module fifo_stream_reader #(
  parameter int FIFO_W  = fifo_stream_pkg::FIFO_W,
  parameter int BUF_D   = 3,
  parameter int PKT_LEN = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   drain_en,
  input  logic                                   fifo_empty,
  input  logic [FIFO_W-1:0]                      fifo_data,
  output logic                                   fifo_read_en,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [FIFO_W-1:0]                      m_data,
  output logic                                   m_last,
  output logic [fifo_stream_pkg::WORD_CNT_W-1:0] word_count,
  output logic                                   busy
);

  import fifo_stream_pkg::*;

  localparam int OW = clog2_min1(BUF_D + 1);
  localparam int BW = clog2_min1(PKT_LEN);

  logic [OW-1:0]         w_occ;
  logic                  w_credit;
  logic                  w_pop;
  logic                  r_inflight;
  logic [BW-1:0]         r_beat;
  logic [WORD_CNT_W-1:0] r_word_count;

  // A read may issue only if a slot is free after counting the word already in flight
  assign w_credit = (int'(w_occ) + int'(r_inflight)) < BUF_D;

  // Held low during reset so a refilled FIFO is not read before the block is released
  assign fifo_read_en = reset_n & drain_en & ~fifo_empty & w_credit;

  assign m_valid = (w_occ != '0);
  assign w_pop   = m_valid & m_ready;
  assign m_last  = m_valid & (r_beat == BW'(PKT_LEN - 1));
  assign busy    = r_inflight | m_valid;

  assign word_count = r_word_count;

  // FIFO data_out is registered, so the word arrives one cycle after the read pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_read_en;
    end
  end

  // Beat position within the packet and running delivered-word total
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat       <= '0;
      r_word_count <= '0;
    end else if (w_pop) begin
      r_beat       <= (r_beat == BW'(PKT_LEN - 1)) ? '0 : r_beat + BW'(1);
      r_word_count <= r_word_count + WORD_CNT_W'(1);
    end
  end

  stream_buffer #(
    .W (FIFO_W),
    .D (BUF_D)
  ) u_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .o_head_data (m_data),
    .o_occ       (w_occ)
  );

endmodule
